// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction queue: compacts 2-wide partially valid fetch groups into a circular
// store and presents the two oldest entries to decode. Define FETCH_BUF_PERF_EN for perf counters.
module fetch_buffer #(
  parameter int DEPTH         = 8,
  parameter int CPU_ADDR_BITS = 32,
  parameter int CPU_INST_BITS = 32,
  parameter logic [CPU_INST_BITS-1:0] PAD_INST = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [1:0]               fetch_val,
  input  logic [CPU_ADDR_BITS-1:0] fetch_pc0,
  input  logic [CPU_ADDR_BITS-1:0] fetch_pc1,
  input  logic [CPU_INST_BITS-1:0] fetch_inst0,
  input  logic [CPU_INST_BITS-1:0] fetch_inst1,
  output logic                     fetch_rdy,
  input  logic                     decode_rdy,
  output logic [CPU_ADDR_BITS-1:0] inst0_pc,
  output logic [CPU_ADDR_BITS-1:0] inst1_pc,
  output logic [CPU_INST_BITS-1:0] inst0,
  output logic [CPU_INST_BITS-1:0] inst1,
  output logic                     inst_val
`ifdef FETCH_BUF_PERF_EN
  ,
  output logic [31:0]              perf_empty_cyc,
  output logic [31:0]              perf_full_cyc
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CPU_ADDR_BITS-1:0] mem_pc   [DEPTH];
  logic [CPU_INST_BITS-1:0] mem_inst [DEPTH];

  logic [PW-1:0] head, tail;
  logic [PW-1:0] head1, tail1;
  logic [CW-1:0] count;
  logic [CW-1:0] push_cnt, pop_cnt;
  logic          push_en, pop_en;

  assign head1 = head + 1'b1;
  assign tail1 = tail + 1'b1;

  // Handshake: a group is taken when fetch_rdy && |fetch_val; a pair leaves when inst_val && decode_rdy.
  always_comb begin
    inst_val  = (count != '0) && !flush;
    fetch_rdy = ((CW'(DEPTH) - count) >= CW'(2)) && !flush;
    push_en   = (fetch_val != 2'b00) && fetch_rdy;
    pop_en    = inst_val && decode_rdy;
    push_cnt  = '0;
    pop_cnt   = '0;
    if (push_en) push_cnt = (fetch_val == 2'b11) ? CW'(2) : CW'(1);
    if (pop_en)  pop_cnt  = (count >= CW'(2)) ? CW'(2) : CW'(1);
  end

  // A lone entry is always padded, even when a push lands behind it this cycle.
  always_comb begin
    inst0_pc = '0;
    inst0    = '0;
    inst1_pc = '0;
    inst1    = '0;
    if (count != '0) begin
      inst0_pc = mem_pc[head];
      inst0    = mem_inst[head];
      if (count >= CW'(2)) begin
        inst1_pc = mem_pc[head1];
        inst1    = mem_inst[head1];
      end else begin
        inst1_pc = mem_pc[head] + CPU_ADDR_BITS'(4);
        inst1    = PAD_INST;
      end
    end
  end

  // Storage carries no reset; occupancy is governed solely by head/tail/count.
  always_ff @(posedge clk) begin
    if (push_en) begin
      if (fetch_val[0]) begin
        mem_pc[tail]   <= fetch_pc0;
        mem_inst[tail] <= fetch_inst0;
        if (fetch_val[1]) begin
          mem_pc[tail1]   <= fetch_pc1;
          mem_inst[tail1] <= fetch_inst1;
        end
      end else begin
        mem_pc[tail]   <= fetch_pc1;
        mem_inst[tail] <= fetch_inst1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_cnt[PW-1:0];
      tail  <= tail + push_cnt[PW-1:0];
      count <= count + push_cnt - pop_cnt;
    end
  end

`ifdef FETCH_BUF_PERF_EN
  // Saturating event counters; flush intentionally leaves them running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_empty_cyc <= '0;
      perf_full_cyc  <= '0;
    end else begin
      if ((count == '0) && !flush && (perf_empty_cyc != 32'hFFFF_FFFF))
        perf_empty_cyc <= perf_empty_cyc + 32'd1;
      if (!fetch_rdy && !flush && (fetch_val != 2'b00) && (perf_full_cyc != 32'hFFFF_FFFF))
        perf_full_cyc <= perf_full_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: driver tasks issue groups, a negedge monitor checks
// every presented pair against an expected queue of {pc,inst} entries.
module tb_fetch_buffer;

  localparam int DEPTH = 8;
  localparam logic [31:0] PAD = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  fetch_val;
  logic [31:0] fetch_pc0, fetch_pc1, fetch_inst0, fetch_inst1;
  logic        fetch_rdy;
  logic        decode_rdy;
  logic [31:0] inst0_pc, inst1_pc, inst0, inst1;
  logic        inst_val;
`ifdef FETCH_BUF_PERF_EN
  logic [31:0] perf_empty_cyc, perf_full_cyc;
`endif

  int checks = 0;
  int errors = 0;

  // scoreboard state: entries are {pc, inst}
  logic [63:0] exp_q[$];
  logic [63:0] pend_q[$];
  int          pend_pop = 0;
  logic        pend_flush = 1'b0;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_val(fetch_val),
    .fetch_pc0(fetch_pc0), .fetch_pc1(fetch_pc1),
    .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
    .fetch_rdy(fetch_rdy), .decode_rdy(decode_rdy),
    .inst0_pc(inst0_pc), .inst1_pc(inst1_pc), .inst0(inst0), .inst1(inst1),
    .inst_val(inst_val)
`ifdef FETCH_BUF_PERF_EN
    , .perf_empty_cyc(perf_empty_cyc), .perf_full_cyc(perf_full_cyc)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: compare outputs with the model before each edge, record what the edge will do
  always @(negedge clk) begin
    int   n;
    logic exp_val, exp_rdy;
    n       = exp_q.size();
    exp_val = (n != 0) && !flush;
    exp_rdy = ((DEPTH - n) >= 2) && !flush;
    chk("inst_val", 64'(inst_val), 64'(exp_val));
    chk("fetch_rdy", 64'(fetch_rdy), 64'(exp_rdy));
    chk("count", 64'(dut.count), 64'(n));
    pend_q.delete();
    pend_pop   = 0;
    pend_flush = flush;
    if (exp_val && decode_rdy) begin
      chk("inst0_pc", 64'(inst0_pc), 64'(exp_q[0][63:32]));
      chk("inst0", 64'(inst0), 64'(exp_q[0][31:0]));
      if (n >= 2) begin
        chk("inst1_pc", 64'(inst1_pc), 64'(exp_q[1][63:32]));
        chk("inst1", 64'(inst1), 64'(exp_q[1][31:0]));
        pend_pop = 2;
      end else begin
        chk("pad_pc", 64'(inst1_pc), 64'(exp_q[0][63:32] + 32'd4));
        chk("pad_inst", 64'(inst1), 64'(PAD));
        pend_pop = 1;
      end
    end
    if (exp_rdy && rst_n) begin
      if (fetch_val[0]) pend_q.push_back({fetch_pc0, fetch_inst0});
      if (fetch_val[1]) pend_q.push_back({fetch_pc1, fetch_inst1});
    end
  end

  // model update at the edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      pend_q.delete();
      pend_pop = 0;
    end else if (pend_flush) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < pend_pop; i++) void'(exp_q.pop_front());
      foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
    end
  end

  // driver: present a group and hold it until accepted
  task automatic push_group(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                            input logic [31:0] p1, input logic [31:0] i1);
    int   waited = 0;
    logic acc = 1'b0;
    fetch_val = v; fetch_pc0 = p0; fetch_inst0 = i0; fetch_pc1 = p1; fetch_inst1 = i1;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = fetch_rdy;
      step();
      waited++;
    end
    fetch_val = 2'b00;
    chk("push_accepted", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    decode_rdy = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; fetch_val = 2'b00; decode_rdy = 1'b0;
    fetch_pc0 = '0; fetch_pc1 = '0; fetch_inst0 = '0; fetch_inst1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst_val", 64'(inst_val), 64'd0);
    chk("rst_fetch_rdy", 64'(fetch_rdy), 64'd1);
    chk("rst_outs", {inst0, inst1}, 64'd0);
    chk("rst_pcs", {inst0_pc, inst1_pc}, 64'd0);
    rst_n = 1'b1;
    step();

    // 1: full pair held, then popped
    push_group(2'b11, 32'h100, 32'h00500093, 32'h104, 32'h00A00113);
    chk("t1_pc0", 64'(inst0_pc), 64'h100);
    chk("t1_pc1", 64'(inst1_pc), 64'h104);
    chk("t1_count", 64'(dut.count), 64'd2);
    decode_rdy = 1'b1;
    step();
    chk("t1_empty", 64'(inst_val), 64'd0);

    // 2: lone slot-1 instruction is padded
    decode_rdy = 1'b0;
    push_group(2'b10, 32'h0, 32'h0, 32'h208, 32'h00100193);
    chk("t2_pc0", 64'(inst0_pc), 64'h208);
    chk("t2_inst1", 64'(inst1), 64'h0);
    chk("t2_pc1", 64'(inst1_pc), 64'h20C);
    chk("t2_val", 64'(inst_val), 64'd1);
    decode_rdy = 1'b1;
    step();
    decode_rdy = 1'b0;
    chk("t2_empty", 64'(inst_val), 64'd0);

    // 3: fill to full, then stream across the wrap
    for (int g = 0; g < 4; g++)
      push_group(2'b11, 32'h300 + 8*g, 32'h1000 + 2*g, 32'h304 + 8*g, 32'h1001 + 2*g);
    chk("t3_full_rdy", 64'(fetch_rdy), 64'd0);
    chk("t3_full_count", 64'(dut.count), 64'd8);
    decode_rdy = 1'b1;
    for (int g = 4; g < 10; g++)
      push_group(2'b11, 32'h300 + 8*g, 32'h1000 + 2*g, 32'h304 + 8*g, 32'h1001 + 2*g);
    drain();

    // 4: simultaneous push and pop at count 5
    decode_rdy = 1'b0;
    push_group(2'b11, 32'h400, 32'h2000, 32'h404, 32'h2001);
    push_group(2'b11, 32'h408, 32'h2002, 32'h40C, 32'h2003);
    push_group(2'b01, 32'h410, 32'h2004, 32'h0, 32'h0);
    chk("t4_count5", 64'(dut.count), 64'd5);
    decode_rdy = 1'b1;
    push_group(2'b11, 32'h414, 32'h2005, 32'h418, 32'h2006);
    decode_rdy = 1'b0;
    chk("t4_count_hold", 64'(dut.count), 64'd5);
    drain();

    // 5: flush wins over push and pop
    decode_rdy = 1'b0;
    for (int g = 0; g < 3; g++)
      push_group(2'b11, 32'h500 + 8*g, 32'h3000 + 2*g, 32'h504 + 8*g, 32'h3001 + 2*g);
    flush = 1'b1; decode_rdy = 1'b1;
    fetch_val = 2'b11; fetch_pc0 = 32'h666; fetch_pc1 = 32'h66A;
    #1;
    chk("t5_flush_val", 64'(inst_val), 64'd0);
    chk("t5_flush_rdy", 64'(fetch_rdy), 64'd0);
    step();
    flush = 1'b0; fetch_val = 2'b00;
    chk("t5_count0", 64'(dut.count), 64'd0);
    chk("t5_val0", 64'(inst_val), 64'd0);

    // 6: asynchronous reset mid-stream
    decode_rdy = 1'b0;
    push_group(2'b11, 32'h600, 32'h4000, 32'h604, 32'h4001);
    push_group(2'b01, 32'h608, 32'h4002, 32'h0, 32'h0);
    chk("t6_count3", 64'(dut.count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_val", 64'(inst_val), 64'd0);
    chk("t6_async_count", 64'(dut.count), 64'd0);
    step();
    rst_n = 1'b1;
`ifdef FETCH_BUF_PERF_EN
    chk("t6_perf_empty0", 64'(perf_empty_cyc), 64'd0);
`endif
    push_group(2'b01, 32'h700, 32'h5000, 32'h0, 32'h0);
    chk("t6_first_pc", 64'(inst0_pc), 64'h700);
    chk("t6_first_inst", 64'(inst0), 64'h5000);
`ifdef FETCH_BUF_PERF_EN
    chk("t6_perf_empty1", 64'(perf_empty_cyc), 64'd1);
`endif
    drain();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
